// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a dual-port SRAM: one write and one read per cycle.
// Optional read-during-write forwarding is enabled by defining SRAM_ARB_FWD_EN.
module sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    sram_wen_o,
  output logic [ADDR_WIDTH-1:0]   sram_waddr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  output logic [ADDR_WIDTH-1:0]   sram_raddr_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

  logic       prio_q;
  logic [1:0] wr_req, rd_req;
  logic [1:0] wr_gnt, rd_gnt;
  logic       conflict;

  always_comb begin
    wr_req = req_i & we_i;
    rd_req = req_i & ~we_i;
    wr_gnt = wr_req;
    rd_gnt = rd_req;
    // Only one op type can be contended with two requesters.
    if (&wr_req) wr_gnt = prio_q ? 2'b10 : 2'b01;
    if (&rd_req) rd_gnt = prio_q ? 2'b10 : 2'b01;
    conflict = (&wr_req) | (&rd_req);
    gnt_o    = wr_gnt | rd_gnt;
  end

  always_comb begin
    sram_wen_o   = |wr_gnt;
    sram_waddr_o = '0;
    sram_wdata_o = '0;
    sram_raddr_o = '0;
    if (wr_gnt[1]) begin
      sram_waddr_o = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
      sram_wdata_o = wdata_i[DATA_WIDTH +: DATA_WIDTH];
    end else if (wr_gnt[0]) begin
      sram_waddr_o = addr_i[0 +: ADDR_WIDTH];
      sram_wdata_o = wdata_i[0 +: DATA_WIDTH];
    end
    if (rd_gnt[1])      sram_raddr_o = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
    else if (rd_gnt[0]) sram_raddr_o = addr_i[0 +: ADDR_WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= 1'b0;
      rvalid_o <= 2'b00;
    end else begin
      rvalid_o <= rd_gnt;
      // Favour the loser next time.
      if (conflict) prio_q <= ~prio_q;
    end
  end

`ifdef SRAM_ARB_FWD_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic                  collide;

  assign collide = sram_wen_o & (|rd_gnt) & (sram_waddr_o == sram_raddr_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q <= collide;
      if (collide) fwd_data_q <= sram_wdata_o;
    end
  end

  assign rdata_o = fwd_q ? fwd_data_q : sram_rdata_i;
`else
  assign rdata_o = sram_rdata_i;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural dual-port SRAM beside it.
module tb_sram_arbiter;
  localparam int DW = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          sram_wen;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic [DW-1:0] mem [0:511];

  typedef struct packed {
    logic [1:0]    rv;
    logic          chk;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [int];
  int            n_vec = 0;
  int            n_err = 0;

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_wen_o(sram_wen), .sram_waddr_o(sram_waddr), .sram_wdata_o(sram_wdata),
    .sram_raddr_o(sram_raddr), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_wen) mem[sram_waddr] <= sram_wdata;
    sram_rdata <= mem[sram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One arbitration cycle: drive, check grant and SRAM port, then check last cycle's read return.
  task automatic cycle(input logic [1:0] r, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] exp_gnt);
    logic [1:0]    wg, rg;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd;
    exp_t          e, got_e;
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    #1;
    check("gnt", gnt, exp_gnt);
    wg  = exp_gnt & r & w;
    rg  = exp_gnt & r & ~w;
    ewa = wg[1] ? a1 : wg[0] ? a0 : '0;
    ewd = wg[1] ? d1 : wg[0] ? d0 : '0;
    era = rg[1] ? a1 : rg[0] ? a0 : '0;
    check("wen", sram_wen, |wg);
    check("waddr", sram_waddr, ewa);
    check("wdata", sram_wdata, ewd);
    check("raddr", sram_raddr, era);
    e.rv = rg; e.chk = 1'b0; e.data = '0;
    if (|rg) begin
`ifdef SRAM_ARB_FWD_EN
      if (|wg && ewa == era) begin
        e.chk = 1'b1; e.data = ewd;
      end else
`endif
      if (ref_mem.exists(int'(era))) begin
        e.chk = 1'b1; e.data = ref_mem[int'(era)];
      end
    end
    sb_q.push_back(e);
    if (|wg) ref_mem[int'(ewa)] = ewd;
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check("rvalid", rvalid, got_e.rv);
    if (got_e.chk) check("rdata", rdata, got_e.data);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b11; we = 2'b00;
    addr = {9'h002, 9'h001}; wdata = '0;
    #1;
    check("rst_gnt", gnt, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", rvalid, 2'b00);
    rst_n = 1'b1;

    // preload; first conflict after reset goes to requester 0
    cycle(2'b11, 2'b11, 9'h001, 9'h002, 8'h11, 8'h22, 2'b01);
    cycle(2'b11, 2'b11, 9'h030, 9'h002, 8'h00, 8'h22, 2'b10);
    cycle(2'b01, 2'b01, 9'h030, 9'h000, 8'h00, 8'h00, 2'b01);
    cycle(2'b01, 2'b01, 9'h020, 9'h000, 8'h5A, 8'h00, 2'b01);

    // write then read from the other requester
    cycle(2'b01, 2'b01, 9'h010, 9'h000, 8'hA5, 8'h00, 2'b01);
    cycle(2'b10, 2'b00, 9'h000, 9'h010, 8'h00, 8'h00, 2'b10);
    cycle(2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00);

    // same-op read conflict alternates
    for (int i = 0; i < 4; i++)
      cycle(2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, (i % 2 == 0) ? 2'b01 : 2'b10);

    // mixed ops proceed together, then verify the write
    cycle(2'b11, 2'b10, 9'h020, 9'h021, 8'h00, 8'h3C, 2'b11);
    cycle(2'b01, 2'b00, 9'h021, 9'h000, 8'h00, 8'h00, 2'b01);

    // read-during-write collision, then a clean re-read
    cycle(2'b11, 2'b10, 9'h030, 9'h030, 8'h00, 8'h77, 2'b11);
    cycle(2'b01, 2'b00, 9'h030, 9'h000, 8'h00, 8'h00, 2'b01);
    cycle(2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00);

    // move prio to 1, then reset with a read in flight
    cycle(2'b11, 2'b11, 9'h040, 9'h041, 8'h01, 8'h02, 2'b01);
    req = 2'b01; we = 2'b00; addr = {9'h000, 9'h010};
    #1;
    check("mid_gnt", gnt, 2'b01);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rvalid", rvalid, 2'b00);
    req = 2'b00;
    rst_n = 1'b1;
    cycle(2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00);
    cycle(2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 2'b01);
    cycle(2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
